// File: rtl/pma_region_table_if.sv
// Config-write and lookup request/result bundle for the PMA region table.
interface pma_region_table_if #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdxW      = 2
);
    logic                 cfg_we_i;
    logic [IdxW-1:0]      cfg_idx_i;
    logic [AddrWidth-1:0] cfg_base_i;
    logic [AddrWidth-1:0] cfg_len_i;
    logic [3:0]           cfg_attr_i;
    logic                 cfg_lock_i;
    logic                 cfg_err_o;

    logic                 lkp_valid_i;
    logic                 lkp_ready_o;
    logic [AddrWidth-1:0] lkp_addr_i;

    logic                 res_valid_o;
    logic                 res_ready_i;
    logic                 res_hit_o;
    logic [IdxW-1:0]      res_idx_o;
    logic [3:0]           res_attr_o;

    modport master (
        output cfg_we_i, cfg_idx_i, cfg_base_i, cfg_len_i, cfg_attr_i, cfg_lock_i,
        input  cfg_err_o,
        output lkp_valid_i, lkp_addr_i,
        input  lkp_ready_o,
        input  res_valid_o, res_hit_o, res_idx_o, res_attr_o,
        output res_ready_i
    );

    modport slave (
        input  cfg_we_i, cfg_idx_i, cfg_base_i, cfg_len_i, cfg_attr_i, cfg_lock_i,
        output cfg_err_o,
        input  lkp_valid_i, lkp_addr_i,
        output lkp_ready_o,
        output res_valid_o, res_hit_o, res_idx_o, res_attr_o,
        input  res_ready_i
    );
endinterface

// File: rtl/pma_region_table.sv
// Programmable physical-memory-attribute region table: lowest-index match lookup
// with a one-deep registered result stage and lockable region configuration.
module pma_region_table #(
    parameter int unsigned NrRegions = 4,
    parameter int unsigned AddrWidth = 64,
    parameter logic [NrRegions-1:0][AddrWidth-1:0] RstBase = (NrRegions*AddrWidth)'(64'h8000_0000),
    parameter logic [NrRegions-1:0][AddrWidth-1:0] RstLen  = (NrRegions*AddrWidth)'(64'h4000_0000),
    parameter logic [NrRegions-1:0][3:0]           RstAttr = (NrRegions*4)'(4'b0111),
    parameter logic [3:0]                          DefaultAttr = 4'b1000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    pma_region_table_if.slave   bus
);
    localparam int unsigned IdxW = (NrRegions > 1) ? $clog2(NrRegions) : 1;

    logic [AddrWidth-1:0] base_q [NrRegions];
    logic [AddrWidth-1:0] len_q  [NrRegions];
    logic [3:0]           attr_q [NrRegions];
    logic [NrRegions-1:0] lock_q;

    logic            res_valid_q, res_hit_q, cfg_err_q;
    logic [IdxW-1:0] res_idx_q;
    logic [3:0]      res_attr_q;

    logic            res_hit_d;
    logic [IdxW-1:0] res_idx_d;
    logic [3:0]      res_attr_d;
    logic            cfg_err_d;
    logic            cfg_sel_ok;
    logic            cfg_sel_locked;
    logic            lkp_fire;

    assign bus.lkp_ready_o = !res_valid_q || bus.res_ready_i;
    assign lkp_fire        = bus.lkp_valid_i && bus.lkp_ready_o;

    // Match against current (pre-write) state; descending scan leaves lowest index winning.
    always_comb begin
        res_hit_d      = 1'b0;
        res_idx_d      = '0;
        res_attr_d     = DefaultAttr;
        cfg_sel_ok     = 1'b0;
        cfg_sel_locked = 1'b0;
        for (int i = int'(NrRegions) - 1; i >= 0; i--) begin
            if ((len_q[i] != '0) && (bus.lkp_addr_i >= base_q[i]) &&
                ({1'b0, bus.lkp_addr_i} < ({1'b0, base_q[i]} + {1'b0, len_q[i]}))) begin
                res_hit_d  = 1'b1;
                res_idx_d  = IdxW'(i);
                res_attr_d = attr_q[i];
            end
        end
        for (int i = 0; i < int'(NrRegions); i++) begin
            if (bus.cfg_idx_i == IdxW'(i)) begin
                cfg_sel_ok     = 1'b1;
                cfg_sel_locked = lock_q[i];
            end
        end
        cfg_err_d = bus.cfg_we_i && (!cfg_sel_ok || cfg_sel_locked);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NrRegions); i++) begin
                base_q[i] <= RstBase[i];
                len_q[i]  <= RstLen[i];
                attr_q[i] <= RstAttr[i];
            end
            lock_q      <= '0;
            cfg_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_hit_q   <= 1'b0;
            res_idx_q   <= '0;
            res_attr_q  <= DefaultAttr;
        end else begin
            cfg_err_q <= cfg_err_d;
            for (int i = 0; i < int'(NrRegions); i++) begin
                if (bus.cfg_we_i && (bus.cfg_idx_i == IdxW'(i)) && !lock_q[i]) begin
                    base_q[i] <= bus.cfg_base_i;
                    len_q[i]  <= bus.cfg_len_i;
                    attr_q[i] <= bus.cfg_attr_i;
                    lock_q[i] <= bus.cfg_lock_i;
                end
            end
            if (lkp_fire) begin
                res_valid_q <= 1'b1;
                res_hit_q   <= res_hit_d;
                res_idx_q   <= res_idx_d;
                res_attr_q  <= res_attr_d;
            end else if (bus.res_ready_i) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.cfg_err_o   = cfg_err_q;
    assign bus.res_valid_o = res_valid_q;
    assign bus.res_hit_o   = res_hit_q;
    assign bus.res_idx_o   = res_idx_q;
    assign bus.res_attr_o  = res_attr_q;
endmodule

// File: tb/tb_pma_region_table.sv
// Directed bench for pma_region_table: expected lookup results queued on acceptance,
// compared on the result handshake.
module tb_pma_region_table;
    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
        logic [3:0] attr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pma_region_table_if #(.AddrWidth(64), .IdxW(2)) bus ();

    pma_region_table dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    exp_t sb[$];
    exp_t pend;
    int   vec   = 0;
    int   errs  = 0;
    int   npops = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: settle, score the result handshake, queue the accepted lookup, advance.
    task automatic tick();
        exp_t e;
        logic acc, cons;
        #1;
        acc  = bus.lkp_valid_i && bus.lkp_ready_o;
        cons = bus.res_valid_o && bus.res_ready_i;
        if (cons) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                npops++;
                chk("res_hit",  64'(bus.res_hit_o),  64'(e.hit));
                chk("res_idx",  64'(bus.res_idx_o),  64'(e.idx));
                chk("res_attr", 64'(bus.res_attr_o), 64'(e.attr));
            end
        end
        if (acc) sb.push_back(pend);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.lkp_valid_i = 1'b0;
        bus.cfg_we_i    = 1'b0;
        tick();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic cfg(input logic [1:0] idx, input logic [63:0] base, input logic [63:0] len,
                       input logic [3:0] attr, input logic lock);
        bus.cfg_we_i   = 1'b1;
        bus.cfg_idx_i  = idx;
        bus.cfg_base_i = base;
        bus.cfg_len_i  = len;
        bus.cfg_attr_i = attr;
        bus.cfg_lock_i = lock;
        tick();
        bus.cfg_we_i = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [63:0] addr, input logic hit,
                          input logic [1:0] idx, input logic [3:0] attr);
        bus.res_ready_i = 1'b1;
        bus.lkp_valid_i = 1'b1;
        bus.lkp_addr_i  = addr;
        pend = '{hit: hit, idx: idx, attr: attr};
        tick();
        bus.lkp_valid_i = 1'b0;
        chk({tag, "_lat"}, 64'(bus.res_valid_o), 64'd1);
        tick();
    endtask

    initial begin
        int p0;
        bus.cfg_we_i = 1'b0; bus.cfg_idx_i = '0; bus.cfg_base_i = '0; bus.cfg_len_i = '0;
        bus.cfg_attr_i = '0; bus.cfg_lock_i = 1'b0;
        bus.lkp_valid_i = 1'b0; bus.lkp_addr_i = '0; bus.res_ready_i = 1'b1;
        pend = '0;

        // Reset state
        tick();
        do_reset();
        chk("rst_valid", 64'(bus.res_valid_o), 64'd0);
        chk("rst_err",   64'(bus.cfg_err_o),   64'd0);
        chk("rst_hit",   64'(bus.res_hit_o),   64'd0);
        chk("rst_idx",   64'(bus.res_idx_o),   64'd0);
        chk("rst_attr",  64'(bus.res_attr_o),  64'b1000);
        chk("rst_ready", 64'(bus.lkp_ready_o), 64'd1);

        // Reset-default region 0 and a miss
        lookup("r0_hit", 64'h8000_1000, 1'b1, 2'd0, 4'b0111);
        lookup("miss0",  64'h0001_0000, 1'b0, 2'd0, 4'b1000);
        lookup("r0_end", 64'hBFFF_FFFF, 1'b1, 2'd0, 4'b0111);
        lookup("r0_out", 64'hC000_0000, 1'b0, 2'd0, 4'b1000);

        // Program region 1, check both edges
        cfg(2'd1, 64'h1_0000, 64'h1_0000, 4'b0100, 1'b0);
        chk("w1_err", 64'(bus.cfg_err_o), 64'd0);
        lookup("r1_base", 64'h1_0000, 1'b1, 2'd1, 4'b0100);
        lookup("r1_last", 64'h1_FFFF, 1'b1, 2'd1, 4'b0100);
        lookup("r1_end",  64'h2_0000, 1'b0, 2'd0, 4'b1000);

        // Overlap: lowest index wins; disabling region 0 exposes region 2
        cfg(2'd2, 64'h9000_0000, 64'h1000, 4'b0001, 1'b0);
        lookup("ovl_r0", 64'h9000_0000, 1'b1, 2'd0, 4'b0111);
        cfg(2'd0, 64'h8000_0000, 64'h0, 4'b0111, 1'b0);
        lookup("ovl_r2", 64'h9000_0000, 1'b1, 2'd2, 4'b0001);
        lookup("r0_off", 64'h8000_1000, 1'b0, 2'd0, 4'b1000);

        // Lock region 1, rejected rewrite, reset clears lock
        cfg(2'd1, 64'h1_0000, 64'h1_0000, 4'b0100, 1'b1);
        chk("lock_err0", 64'(bus.cfg_err_o), 64'd0);
        cfg(2'd1, 64'h0, 64'h1_0000, 4'b0100, 1'b0);
        chk("lock_err1", 64'(bus.cfg_err_o), 64'd1);
        tick();
        chk("lock_err_pulse", 64'(bus.cfg_err_o), 64'd0);
        lookup("lock_keep", 64'h1_8000, 1'b1, 2'd1, 4'b0100);
        lookup("lock_noapply", 64'h8000, 1'b0, 2'd0, 4'b1000);
        do_reset();
        lookup("rst_r0_back", 64'h8000_1000, 1'b1, 2'd0, 4'b0111);
        lookup("rst_r2_gone", 64'h9000_0000 + 64'h4000_0000, 1'b0, 2'd0, 4'b1000);
        cfg(2'd1, 64'h0, 64'h1_0000, 4'b0100, 1'b0);
        chk("unlock_err", 64'(bus.cfg_err_o), 64'd0);
        lookup("unlock_hit", 64'h8000, 1'b1, 2'd1, 4'b0100);

        // Backpressure: one stalled result, next request held off, then stream
        p0 = npops;
        bus.res_ready_i = 1'b0;
        bus.lkp_valid_i = 1'b1;
        bus.lkp_addr_i  = 64'h8000_0000;
        pend = '{hit: 1'b1, idx: 2'd0, attr: 4'b0111};
        tick();
        bus.lkp_addr_i = 64'h0000_0004;
        pend = '{hit: 1'b1, idx: 2'd1, attr: 4'b0100};
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_ready", 64'(bus.lkp_ready_o), 64'd0);
            chk("bp_valid", 64'(bus.res_valid_o), 64'd1);
            chk("bp_idx",   64'(bus.res_idx_o),   64'd0);
            chk("bp_attr",  64'(bus.res_attr_o),  64'b0111);
        end
        bus.res_ready_i = 1'b1;
        tick();
        bus.lkp_addr_i = 64'hF000_0000;
        pend = '{hit: 1'b0, idx: 2'd0, attr: 4'b1000};
        tick();
        bus.lkp_valid_i = 1'b0;
        tick();
        tick();
        chk("bp_pops",  64'(npops - p0), 64'd3);
        chk("bp_drain", 64'(sb.size()),  64'd0);

        // Top-of-address-space region and same-cycle write/lookup
        cfg(2'd3, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 4'b0101, 1'b0);
        lookup("top_hit",  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2'd3, 4'b0101);
        lookup("top_below", 64'hFFFF_FFFF_FFFF_EFFF, 1'b0, 2'd0, 4'b1000);
        bus.cfg_we_i = 1'b1; bus.cfg_idx_i = 2'd3; bus.cfg_base_i = 64'hFFFF_FFFF_FFFF_F000;
        bus.cfg_len_i = 64'h1000; bus.cfg_attr_i = 4'b0011; bus.cfg_lock_i = 1'b0;
        bus.lkp_valid_i = 1'b1; bus.lkp_addr_i = 64'hFFFF_FFFF_FFFF_F800;
        pend = '{hit: 1'b1, idx: 2'd3, attr: 4'b0101};
        tick();
        bus.cfg_we_i = 1'b0;
        bus.lkp_valid_i = 1'b0;
        tick();
        lookup("top_new", 64'hFFFF_FFFF_FFFF_F800, 1'b1, 2'd3, 4'b0011);

        // Reset while a result is stalled
        bus.res_ready_i = 1'b0;
        bus.lkp_valid_i = 1'b1;
        bus.lkp_addr_i  = 64'h8000_0000;
        pend = '{hit: 1'b1, idx: 2'd0, attr: 4'b0111};
        tick();
        bus.lkp_valid_i = 1'b0;
        tick();
        chk("stall_valid", 64'(bus.res_valid_o), 64'd1);
        do_reset();
        chk("rst_flush", 64'(bus.res_valid_o), 64'd0);
        chk("rst_flush_attr", 64'(bus.res_attr_o), 64'b1000);
        chk("rst_flush_ready", 64'(bus.lkp_ready_o), 64'd1);
        bus.res_ready_i = 1'b1;
        tick();
        chk("rst_no_dup", 64'(bus.res_valid_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #200000;
        $fatal(1, "FAIL timeout observed=running expected=finished");
    end
endmodule
